// File: rtl/ram_bank_ctrl.sv
// rtl/ram_bank_ctrl.sv - single-port RAM bank with strobed writes, fixed-latency responses and miss reporting
// Optional power-up clear sweep: define RAM_BANK_CLEAR_EN.
module ram_bank_ctrl #(
    parameter int unsigned          DATA_W     = 64,
    parameter int unsigned          ADDR_W     = 64,
    parameter int unsigned          DEPTH_LOG2 = 8,
    parameter logic [ADDR_W-1:0]    BASE_TAG   = '0,
    parameter int unsigned          READ_LAT   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic [7:0]            err_count
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  accept;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] index;
    logic [DATA_W-1:0]     rd_word;

    logic                  pv_q    [READ_LAT];
    logic                  perr_q  [READ_LAT];
    logic [DATA_W-1:0]     pdata_q [READ_LAT];
    logic [7:0]            err_cnt_q;
    logic [7:0]            err_cnt_d;

`ifdef RAM_BANK_CLEAR_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q;
    logic [DEPTH_LOG2-1:0] clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + DEPTH_LOG2'(1);
            if (clr_idx_q == DEPTH_LOG2'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign req_ready = (state_q == ST_RUN);
`else
    assign req_ready = 1'b1;
`endif

    // Requests presented while reset is held must not touch the array.
    assign accept  = req_valid & req_ready & ~reset;
    assign hit     = (req_addr[ADDR_W-1:DEPTH_LOG2] == BASE_TAG[ADDR_W-1-DEPTH_LOG2:0]);
    assign index   = req_addr[DEPTH_LOG2-1:0];
    assign rd_word = mem_q[index];

    always_ff @(posedge clock) begin
`ifdef RAM_BANK_CLEAR_EN
        if (!reset && state_q == ST_INIT) begin
            mem_q[clr_idx_q] <= '0;
        end else
`endif
        if (accept && req_write && hit) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_strb[i]) begin
                    mem_q[index][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Stage 0 captures the pre-write array word, so a read one cycle after a write sees the new data.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < READ_LAT; s++) begin
                pv_q[s]    <= 1'b0;
                perr_q[s]  <= 1'b0;
                pdata_q[s] <= '0;
            end
        end else begin
            pv_q[0]    <= accept;
            perr_q[0]  <= accept & ~hit;
            pdata_q[0] <= (accept && !req_write && hit) ? rd_word : '0;
            for (int s = 1; s < READ_LAT; s++) begin
                pv_q[s]    <= pv_q[s-1];
                perr_q[s]  <= perr_q[s-1];
                pdata_q[s] <= pdata_q[s-1];
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !hit && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rsp_valid = pv_q[READ_LAT-1];
    assign rsp_err   = perr_q[READ_LAT-1];
    assign rsp_data  = pdata_q[READ_LAT-1];
    assign err_count = err_cnt_q;

endmodule
